// File: rtl/plic_gateway_arb.sv
// Interrupt gateway and multi-target arbiter: synchronises raw lines, tracks per-source
// IDLE/PENDING/INFLIGHT state, and selects the highest-priority enabled source per target.
module plic_gateway_arb #(
  parameter int  IRQ_NUM    = 32,
  parameter int  PRIO_WIDTH = 4,
  parameter int  TGT_NUM    = 2,
  localparam int ID_WIDTH   = $clog2(IRQ_NUM)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [IRQ_NUM-1:0]            irq_i,
  input  logic [IRQ_NUM-1:0]            edge_i,
  input  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i,
  input  logic [TGT_NUM*IRQ_NUM-1:0]    ie_i,
  input  logic [TGT_NUM*PRIO_WIDTH-1:0] thold_i,
  input  logic [TGT_NUM-1:0]            claim_req_i,
  output logic [TGT_NUM*ID_WIDTH-1:0]   claim_rsp_o,
  input  logic [TGT_NUM-1:0]            comp_req_i,
  input  logic [TGT_NUM*ID_WIDTH-1:0]   comp_id_i,
  output logic [IRQ_NUM-1:0]            ip_o,
  output logic [TGT_NUM-1:0]            ext_irq_o
);

  typedef enum logic [1:0] {GW_IDLE, GW_PENDING, GW_INFLIGHT} gw_state_e;

  logic [IRQ_NUM-1:0]    irq_p0, irq_p1, prev_p2, rise;
  gw_state_e             state_q [IRQ_NUM];
  gw_state_e             state_d [IRQ_NUM];
  logic [IRQ_NUM-1:0]    edge_seen_q, edge_seen_d;
  logic [IRQ_NUM-1:0]    claim_hit, comp_hit;
  logic [TGT_NUM-1:0]    grant;
  logic [ID_WIDTH-1:0]   best_id_q [TGT_NUM];
  logic [ID_WIDTH-1:0]   best_id_d [TGT_NUM];
  logic [PRIO_WIDTH-1:0] best_prio [TGT_NUM];
  logic [ID_WIDTH-1:0]   rsp_q [TGT_NUM];

  // Stage p0/p1: two-flop synchroniser; p2: previous sample for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_p0  <= '0;
      irq_p1  <= '0;
      prev_p2 <= '0;
    end else begin
      irq_p0  <= irq_i;
      irq_p1  <= irq_p0;
      prev_p2 <= irq_p1;
    end
  end

  assign rise = irq_p1 & ~prev_p2;

  always_comb begin
    ip_o = '0;
    for (int k = 1; k < IRQ_NUM; k++) ip_o[k] = (state_q[k] == GW_PENDING);
  end

  // Ascending scan with a strict compare keeps the lowest ID on priority ties.
  always_comb begin
    for (int t = 0; t < TGT_NUM; t++) begin
      best_id_d[t] = '0;
      best_prio[t] = '0;
      for (int k = 0; k < IRQ_NUM; k++) begin
        if (ip_o[k] && ie_i[t*IRQ_NUM + k] &&
            (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > thold_i[t*PRIO_WIDTH +: PRIO_WIDTH]) &&
            (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] > best_prio[t])) begin
          best_id_d[t] = ID_WIDTH'(k);
          best_prio[t] = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        end
      end
    end
  end

  // Claims check live PENDING state because best_id lags by a cycle; lower targets win races.
  always_comb begin
    claim_hit = '0;
    grant     = '0;
    for (int t = 0; t < TGT_NUM; t++) begin
      if (claim_req_i[t] && (best_id_q[t] != '0)) begin
        for (int k = 0; k < IRQ_NUM; k++) begin
          if ((best_id_q[t] == ID_WIDTH'(k)) && ip_o[k] && !claim_hit[k]) begin
            claim_hit[k] = 1'b1;
            grant[t]     = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    comp_hit = '0;
    for (int t = 0; t < TGT_NUM; t++) begin
      if (comp_req_i[t]) begin
        for (int k = 0; k < IRQ_NUM; k++) begin
          if (comp_id_i[t*ID_WIDTH +: ID_WIDTH] == ID_WIDTH'(k)) comp_hit[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    edge_seen_d = edge_seen_q;
    for (int k = 0; k < IRQ_NUM; k++) begin
      state_d[k] = state_q[k];
      case (state_q[k])
        GW_IDLE: begin
          if (edge_i[k] ? rise[k] : irq_p1[k]) state_d[k] = GW_PENDING;
        end
        GW_PENDING: begin
          if (claim_hit[k]) begin
            state_d[k] = GW_INFLIGHT;
            if (edge_i[k] && rise[k]) edge_seen_d[k] = 1'b1;
          end
        end
        GW_INFLIGHT: begin
          if (edge_i[k] && rise[k]) edge_seen_d[k] = 1'b1;
          if (comp_hit[k]) begin
            state_d[k]     = (edge_i[k] && edge_seen_d[k]) ? GW_PENDING : GW_IDLE;
            edge_seen_d[k] = 1'b0;
          end
        end
        default: state_d[k] = GW_IDLE;
      endcase
    end
    state_d[0]     = GW_IDLE;
    edge_seen_d[0] = 1'b0;
  end

  // Stage p3: gateway state, arbitration result and claim responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_seen_q <= '0;
      ext_irq_o   <= '0;
      for (int k = 0; k < IRQ_NUM; k++) state_q[k] <= GW_IDLE;
      for (int t = 0; t < TGT_NUM; t++) begin
        best_id_q[t] <= '0;
        rsp_q[t]     <= '0;
      end
    end else begin
      edge_seen_q <= edge_seen_d;
      for (int k = 0; k < IRQ_NUM; k++) state_q[k] <= state_d[k];
      for (int t = 0; t < TGT_NUM; t++) begin
        best_id_q[t] <= best_id_d[t];
        ext_irq_o[t] <= (best_id_d[t] != '0);
        if (claim_req_i[t]) rsp_q[t] <= grant[t] ? best_id_q[t] : '0;
      end
    end
  end

  always_comb begin
    claim_rsp_o = '0;
    for (int t = 0; t < TGT_NUM; t++) claim_rsp_o[t*ID_WIDTH +: ID_WIDTH] = rsp_q[t];
  end

endmodule

// File: tb/tb_plic_gateway_arb.sv
// Directed bench for plic_gateway_arb: expectations queued as stimulus is applied,
// popped and compared when the DUT output is observed.
module tb_plic_gateway_arb;
  localparam int IRQ_NUM    = 32;
  localparam int PRIO_WIDTH = 4;
  localparam int TGT_NUM    = 2;
  localparam int ID_WIDTH   = 5;

  logic                          clk_i = 1'b0;
  logic                          rst_i;
  logic [IRQ_NUM-1:0]            irq_i, edge_i;
  logic [IRQ_NUM*PRIO_WIDTH-1:0] prio_i;
  logic [TGT_NUM*IRQ_NUM-1:0]    ie_i;
  logic [TGT_NUM*PRIO_WIDTH-1:0] thold_i;
  logic [TGT_NUM-1:0]            claim_req_i, comp_req_i;
  logic [TGT_NUM*ID_WIDTH-1:0]   claim_rsp_o, comp_id_i;
  logic [IRQ_NUM-1:0]            ip_o;
  logic [TGT_NUM-1:0]            ext_irq_o;

  plic_gateway_arb #(.IRQ_NUM(IRQ_NUM), .PRIO_WIDTH(PRIO_WIDTH), .TGT_NUM(TGT_NUM)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .irq_i(irq_i), .edge_i(edge_i), .prio_i(prio_i),
    .ie_i(ie_i), .thold_i(thold_i), .claim_req_i(claim_req_i), .claim_rsp_o(claim_rsp_o),
    .comp_req_i(comp_req_i), .comp_id_i(comp_id_i), .ip_o(ip_o), .ext_irq_o(ext_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  function automatic logic [63:0] rsp(input int t);
    return 64'(claim_rsp_o[t*ID_WIDTH +: ID_WIDTH]);
  endfunction

  task automatic set_prio(input int k, input int p);
    prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] = PRIO_WIDTH'(p);
  endtask

  task automatic set_thold(input int t, input int p);
    thold_i[t*PRIO_WIDTH +: PRIO_WIDTH] = PRIO_WIDTH'(p);
  endtask

  task automatic claim(input logic [TGT_NUM-1:0] mask);
    claim_req_i = mask;
    tick();
    claim_req_i = '0;
  endtask

  task automatic complete(input int t, input int id);
    comp_id_i[t*ID_WIDTH +: ID_WIDTH] = ID_WIDTH'(id);
    comp_req_i[t] = 1'b1;
    tick();
    comp_req_i = '0;
  endtask

  task automatic pulse(input int k);
    irq_i[k] = 1'b1;
    tick();
    irq_i[k] = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    irq_i = '0; edge_i = '0; prio_i = '0; ie_i = '0; thold_i = '0;
    claim_req_i = '0; comp_req_i = '0; comp_id_i = '0;
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Level source, single target
    do_reset();
    push("rst_ip", 0);     check(64'(ip_o));
    push("rst_ext", 0);    check(64'(ext_irq_o));
    push("rst_rsp0", 0);   check(rsp(0));
    push("rst_rsp1", 0);   check(rsp(1));
    set_prio(5, 3); ie_i[5] = 1'b1; set_thold(0, 1);
    irq_i[5] = 1'b1;
    tick(); tick(); tick();
    push("lvl_ip_e2", 1);  check(64'(ip_o[5]));
    push("lvl_ext_e2", 0); check(64'(ext_irq_o[0]));
    tick();
    push("lvl_ext_e3", 1); check(64'(ext_irq_o[0]));
    push("lvl_claim", 5);
    claim(2'b01);
    check(rsp(0));
    push("lvl_ip_clr", 0); check(64'(ip_o[5]));
    tick();
    push("lvl_ext_drop", 0); check(64'(ext_irq_o[0]));
    push("lvl_comp_p", 0);
    complete(0, 5);
    check(64'(ip_o[5]));
    tick();
    push("lvl_repend", 1); check(64'(ip_o[5]));

    // Priority and tie-break
    do_reset();
    set_prio(3, 2); set_prio(7, 6); set_prio(9, 6);
    ie_i[3] = 1'b1; ie_i[7] = 1'b1; ie_i[9] = 1'b1;
    irq_i[3] = 1'b1; irq_i[7] = 1'b1; irq_i[9] = 1'b1;
    tick(); tick(); tick(); tick();
    push("pri_ext", 1);    check(64'(ext_irq_o[0]));
    push("pri_c1", 7);     claim(2'b01); check(rsp(0));
    tick();
    push("pri_c2", 9);     claim(2'b01); check(rsp(0));
    tick();
    push("pri_c3", 3);     claim(2'b01); check(rsp(0));
    tick();
    push("pri_ext_none", 0); check(64'(ext_irq_o[0]));
    set_thold(0, 6);
    complete(0, 7);
    tick();
    push("pri_ip7", 1);    check(64'(ip_o[7]));
    tick();
    push("pri_thold6", 0); check(64'(ext_irq_o[0]));
    set_thold(0, 5);
    tick();
    push("pri_thold5", 1); check(64'(ext_irq_o[0]));
    push("pri_c4", 7);     claim(2'b01); check(rsp(0));

    // Edge mode
    do_reset();
    edge_i[4] = 1'b1; set_prio(4, 1); ie_i[4] = 1'b1;
    pulse(4); pulse(4); pulse(4);
    push("edg_ip", 1);     check(64'(ip_o[4]));
    push("edg_ext", 1);    check(64'(ext_irq_o[0]));
    push("edg_c1", 4);     claim(2'b01); check(rsp(0));
    push("edg_ip_clr", 0); check(64'(ip_o[4]));
    tick();
    pulse(4); pulse(4);
    tick(); tick();
    push("edg_repend", 1);
    complete(0, 4);
    check(64'(ip_o[4]));
    tick();
    push("edg_c2", 4);     claim(2'b01); check(rsp(0));
    push("edg_idle", 0);
    complete(0, 4);
    check(64'(ip_o[4]));
    tick(); tick();
    push("edg_idle_ip", 0);  check(64'(ip_o[4]));
    push("edg_idle_ext", 0); check(64'(ext_irq_o[0]));

    // Multi-target race
    do_reset();
    set_prio(2, 1); ie_i[2] = 1'b1; ie_i[IRQ_NUM + 2] = 1'b1;
    irq_i[2] = 1'b1;
    tick(); tick(); tick(); tick();
    push("race_ext", 2'b11); check(64'(ext_irq_o));
    push("race_rsp0", 2);    push("race_rsp1", 0);
    claim(2'b11);
    check(rsp(0));
    check(rsp(1));
    push("race_stale", 0);   claim(2'b10); check(rsp(1));
    push("race_ext_off", 0); check(64'(ext_irq_o));

    // Spurious complete and priority 0
    do_reset();
    complete(0, 6);
    push("spur_ip", 0);    check(64'(ip_o));
    push("spur_ext", 0);   check(64'(ext_irq_o));
    set_prio(8, 0); ie_i[8] = 1'b1; irq_i[8] = 1'b1;
    tick(); tick(); tick(); tick();
    push("p0_ip", 32'h100); check(64'(ip_o));
    push("p0_ext", 0);      check(64'(ext_irq_o[0]));
    push("spur_pend", 1);
    complete(0, 8);
    check(64'(ip_o[8]));
    push("p0_claim", 0);   claim(2'b01); check(rsp(0));

    // Reset mid-operation
    do_reset();
    set_prio(5, 3); set_prio(3, 2); ie_i[5] = 1'b1; ie_i[3] = 1'b1;
    irq_i[5] = 1'b1;
    tick(); tick(); tick(); tick();
    push("mr_c", 5);       claim(2'b01); check(rsp(0));
    irq_i[3] = 1'b1;
    tick(); tick(); tick(); tick();
    push("mr_ip_pre", 32'h8); check(64'(ip_o));
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    push("mr_ip", 0);      check(64'(ip_o));
    push("mr_ext", 0);     check(64'(ext_irq_o));
    push("mr_rsp", 0);     check(rsp(0));
    tick(); tick();
    push("mr_ip5_r2", 0);  check(64'(ip_o[5]));
    tick();
    push("mr_ip5_r3", 1);  check(64'(ip_o[5]));

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/plic_gateway_arb.md
# plic_gateway_arb

Parametrised interrupt gateway and multi-target arbiter for the next-generation PLIC. It extends the 32-source, single-target, 4-bit-priority scheme with configurable source count, priority width and target count, and adds per-source level/edge gateway modes. The block sits between raw peripheral interrupt lines and the PLIC register file. The register file supplies the priority, enable and threshold values and drives the claim/complete strobes; this block returns the pending vector, the per-target interrupt lines and the claim IDs.

## Interface
- `IRQ_NUM`, 32: number of sources including reserved source 0; legal range 2..64.
- `PRIO_WIDTH`, 4: priority and threshold width in bits.
- `TGT_NUM`, 2: number of targets (contexts); legal range 1..8.
- `ID_WIDTH`, $clog2(IRQ_NUM): localparam giving the source ID width.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `irq_i` in IRQ_NUM: raw interrupt lines, asynchronous. Bit 0 is ignored.
- `edge_i` in IRQ_NUM: per-source mode; 1 = rising-edge, 0 = level-high. Quasi-static.
- `prio_i` in IRQ_NUM*PRIO_WIDTH: source k priority is bits [k*PRIO_WIDTH +: PRIO_WIDTH].
- `ie_i` in TGT_NUM*IRQ_NUM: target t enable vector is bits [t*IRQ_NUM +: IRQ_NUM].
- `thold_i` in TGT_NUM*PRIO_WIDTH: per-target threshold.
- `claim_req_i` in TGT_NUM: one-cycle claim strobe per target.
- `claim_rsp_o` out TGT_NUM*ID_WIDTH: registered claim result per target.
- `comp_req_i` in TGT_NUM: one-cycle complete strobe per target.
- `comp_id_i` in TGT_NUM*ID_WIDTH: ID being completed.
- `ip_o` out IRQ_NUM: pending vector; bit 0 is always 0.
- `ext_irq_o` out TGT_NUM: registered interrupt request to each target.

## Operation

**Synchroniser**
- Each `irq_i` bit passes through a 2-flop synchroniser, giving `s2`.
- Edge-mode sources also keep a `prev` flop; a rising edge is `s2 & ~prev`.

**Gateway (per source k ≥ 1)**
- States: IDLE, PENDING, INFLIGHT. Each source also has an `edge_seen` flag.
- IDLE → PENDING:
  - level mode: when `s2` = 1;
  - edge mode: on a rising edge.
- PENDING → INFLIGHT: on a granted claim of k.
  - Edge mode: a rising edge in that same cycle sets `edge_seen`.
  - Extra edges while PENDING merge into the single pending request.
- INFLIGHT:
  - Edge mode: a rising edge sets `edge_seen`. Edges beyond the first are lost; only one is latched.
  - Level mode: `irq_i` is ignored while INFLIGHT.
- INFLIGHT → exit on a complete with `comp_id_i` = k from any target:
  - edge mode with `edge_seen` = 1: go to PENDING and clear `edge_seen`;
  - otherwise: go to IDLE. A level source that is still high re-pends on the next cycle.
- A complete for an ID that is not INFLIGHT, or for ID 0, is ignored.
- `ip_o[k]` = (state == PENDING).

**Arbiter (per target t)**
- A source is a candidate when `ip_o[k]` & `ie[t][k]` & (`prio[k]` > `thold[t]`), using an unsigned strict compare.
- Priority 0 therefore never interrupts.
- The winner is the highest priority; ties go to the lowest ID.
- `best_id[t]` is registered each cycle, and is 0 when there is no candidate.
- `ext_irq_o[t]` is registered as (next `best_id[t]` != 0).

**Claim**
- A claim strobe on `claim_req_i[t]` sets `claim_rsp_o[t]` at the next edge to `best_id[t]`, but only if:
  - that source is still PENDING in the claim cycle, and
  - no lower-index target claims the same ID in that cycle.
- Otherwise the response is 0.
- A granted claim moves the source to INFLIGHT at the same edge.
- `claim_rsp_o[t]` holds its value until the next claim by t.

**Reset**
- `rst_i` applied at any time returns every gateway to IDLE.
- It clears `edge_seen`, `prev`, the synchroniser flops, `best_id`, `ip_o`, `ext_irq_o` and `claim_rsp_o`.
- In-flight IDs are discarded and no completion is needed.

## Timing
- Edge numbering: `irq_i` is first sampled high at edge E.
  - `s2` = 1 after E+1;
  - `ip_o[k]` = 1 after E+2;
  - `best_id` and `ext_irq_o` are valid after E+3.
- Claim at edge C:
  - `claim_rsp_o` is valid after C;
  - `ip_o[k]` = 0 after C;
  - `best_id` and `ext_irq_o` update after C+1, so they are one cycle stale. The PENDING check on claims covers this stale cycle.
- Complete at edge P:
  - gateway leaves INFLIGHT after P;
  - an edge-mode re-pend gives `ip_o` after P;
  - a level-mode re-pend gives `ip_o` after P+1.
- Changes to `prio_i`, `ie_i` or `thold_i` reach `ext_irq_o` one edge later.
- Claim and complete strobes are single-cycle. A strobe held high is treated as a repeat request every cycle.

## Test plan
- **Level, single target.** IRQ 5, prio 3, ie[0][5] = 1, thold 1; hold `irq_i[5]` high. Required:
  - `ext_irq_o[0]` rises 3 edges after sampling;
  - claim gives `claim_rsp_o` = 5;
  - `ext_irq_o[0]` drops;
  - complete(5) with the line still high re-raises `ip_o[5]` after 2 edges.
- **Priority and tie-break.** IRQ 3 at prio 2, IRQ 7 at prio 6, IRQ 9 at prio 6, all enabled. Required:
  - claims return 7, then 9, then 3;
  - setting thold = 6 gives `ext_irq_o` = 0.
- **Edge mode.** IRQ 4 edge mode; three pulses while PENDING, then two pulses while INFLIGHT. Required:
  - first claim returns 4;
  - complete(4) gives immediate PENDING;
  - second claim returns 4;
  - complete(4) gives IDLE with `ip_o[4]` = 0.
- **Multi-target race.** IRQ 2 enabled on targets 0 and 1; both claim in the same cycle. Required:
  - `claim_rsp_o[0]` = 2 and `claim_rsp_o[1]` = 0;
  - a target-1 claim one cycle later (stale `best_id`) returns 0.
- **Spurious complete and priority 0.** Required:
  - complete(6) while IRQ 6 is IDLE changes no state;
  - IRQ 8 at prio 0 with thold 0 never asserts `ext_irq_o`.
- **Reset mid-operation.** IRQ 5 INFLIGHT and IRQ 3 PENDING, then assert `rst_i` for 1 cycle. Required:
  - all outputs are 0;
  - with `irq_i[5]` still high (level mode), `ip_o[5]` re-asserts 3 edges after `rst_i` deasserts.
